serial_frame_transmitter: RTL

Serial frame transmitter that produces the framed bit stream consumed by the team's serial sequence detector. On a start request it latches a 10-bit payload, then emits the fixed 6-bit header `110101` followed by the 10 payload bits, MSB first. It advances one bit per enabled clock (`clkEn`) and exposes a detector-compatible payload counter and valid flag. It sits on the transmit side of the serial link, directly drivable into the detector's `serIn` for loopback.

---
 rtl/serial_frame_transmitter.sv | 73 +++++++
 1 files changed

// File: rtl/serial_frame_transmitter.sv
// Framed serial transmitter: a fixed 6-bit header followed by a 10-bit payload, MSB first.
// Advances one bit per clkEn tick. The counter and valid flag match the detector.
module serial_frame_transmitter #(
    parameter logic [5:0] HEADER = 6'b110101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkEn,
    input  logic       start,
    input  logic [9:0] dataIn,
    output logic       serOut,
    output logic       serOutValid,
    output logic       busy,
    output logic       done,
    output logic [3:0] countOut
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0] state;
    logic [2:0] idx;
    logic [9:0] shreg;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= 3'd5;
            shreg <= '0;
            cnt   <= '0;
        end else if (clkEn) begin
            case (state)
                S_IDLE: if (start) begin
                    shreg <= dataIn;
                    idx   <= 3'd5;
                    state <= S_HEADER;
                end
                S_HEADER: if (idx == 3'd0) begin
                    cnt   <= 4'd6;
                    state <= S_PAYLOAD;
                end else begin
                    idx <= idx - 3'd1;
                end
                S_PAYLOAD: begin
                    shreg <= {shreg[8:0], 1'b0};
                    // The counter stops at 15. It is not reset here, so it holds 15 through DONE and IDLE.
                    if (cnt == 4'd15) state <= S_DONE;
                    else              cnt   <= cnt + 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        serOut      = 1'b0;
        serOutValid = 1'b0;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        case (state)
            S_HEADER: serOut = HEADER[idx];
            S_PAYLOAD: begin
                serOut      = shreg[9];
                serOutValid = 1'b1;
            end
            default: serOut = 1'b0;
        endcase
    end

    assign countOut = cnt;
endmodule
